// File: rtl/sprite_pkg.sv
// Shared definitions for the sprite renderer.
//  - COLOR_W / TRANSPARENT_DEFAULT : colour word width and default see-through colour
//  - DIR_* : one-hot direction codes, bit order {down,up,left,right}
//  - anim_state_t : ping-pong animation direction
//  - is_onehot4 : true when exactly one direction bit is set
package sprite_pkg;

    localparam int COLOR_W = 12;
    localparam logic [COLOR_W-1:0] TRANSPARENT_DEFAULT = 12'h000;

    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    localparam logic [3:0] DIR_LEFT  = 4'b0010;
    localparam logic [3:0] DIR_UP    = 4'b0100;
    localparam logic [3:0] DIR_DOWN  = 4'b1000;

    typedef enum logic {
        ANIM_UP   = 1'b0,
        ANIM_DOWN = 1'b1
    } anim_state_t;

    function automatic logic is_onehot4(input logic [3:0] d);
        return (d != 4'd0) && ((d & (d - 4'd1)) == 4'd0);
    endfunction

endpackage

// File: rtl/sprite_orient.sv
// Combinational orientation mapper.
// Maps the local sprite pixel (r,c) to the ROM source pixel for the given
// one-hot direction. ROM art faces right; the other directions are the
// mirror (left) and the two 90-degree rotations (up, down).
// Ports:
//  r, c      in   RW  local row / column inside the sprite box
//  dir       in   4   one-hot {down,up,left,right}
//  src_row   out  RW  ROM row to fetch
//  src_col   out  RW  ROM column to fetch
module sprite_orient
    import sprite_pkg::*;
#(
    parameter int SPR_SIZE = 30,
    localparam int RW = (SPR_SIZE > 1) ? $clog2(SPR_SIZE) : 1
) (
    input  logic [RW-1:0] r,
    input  logic [RW-1:0] c,
    input  logic [3:0]    dir,
    output logic [RW-1:0] src_row,
    output logic [RW-1:0] src_col
);

    localparam logic [RW-1:0] S = RW'(SPR_SIZE - 1);

    always_comb begin
        src_row = r;
        src_col = c;
        case (dir)
            DIR_LEFT: begin
                src_col = S - c;
            end
            DIR_UP: begin
                src_row = c;
                src_col = S - r;
            end
            DIR_DOWN: begin
                src_row = S - c;
                src_col = r;
            end
            default: begin
                // right (and any stray code) uses the art as stored
            end
        endcase
    end

endmodule

// File: rtl/sprite_view.sv
// Pipelined sprite renderer.
// For each scanned pixel (hc,vc) produces a fill flag and 12-bit colour for a
// square sprite at the latched position, oriented by direction and animated
// with a ping-pong frame sequence. Fixed latency ROM_LATENCY+2, no stalls.
// Ports:
//  clk, rst     clock, asynchronous active-high reset
//  frame_tick   one-cycle pulse per video frame; latches position/direction
//  px_vld       hc/vc in active area
//  hc, vc       scan column / row
//  spr_x, spr_y sprite top-left (shadowed on frame_tick)
//  direction    one-hot {down,up,left,right}
//  anim_en      animate while 1
//  rom_addr     registered sprite ROM address
//  rom_data     ROM colour, ROM_LATENCY cycles after rom_addr
//  out_vld      px_vld delayed
//  sprite_fill  opaque sprite pixel at the delayed (hc,vc)
//  color_data   rom_data when sprite_fill, else 0
module sprite_view
    import sprite_pkg::*;
#(
    parameter int SPR_SIZE    = 30,
    parameter int NUM_FRAMES  = 3,
    parameter int ANIM_DIV    = 4,
    parameter int ROM_LATENCY = 1,
    parameter int COORD_W     = 10,
    parameter logic [COLOR_W-1:0] TRANSPARENT = TRANSPARENT_DEFAULT,
    localparam int ROM_AW = $clog2(NUM_FRAMES * SPR_SIZE * SPR_SIZE)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_tick,
    input  logic               px_vld,
    input  logic [COORD_W-1:0] hc,
    input  logic [COORD_W-1:0] vc,
    input  logic [COORD_W-1:0] spr_x,
    input  logic [COORD_W-1:0] spr_y,
    input  logic [3:0]         direction,
    input  logic               anim_en,
    output logic [ROM_AW-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               out_vld,
    output logic               sprite_fill,
    output logic [COLOR_W-1:0] color_data
);

    localparam int LATENCY = ROM_LATENCY + 2;
    // stages between the address register and the output register
    localparam int DLY     = LATENCY - 2;
    localparam int RW      = (SPR_SIZE > 1) ? $clog2(SPR_SIZE) : 1;
    localparam int FW      = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int DW      = (ANIM_DIV > 1) ? $clog2(ANIM_DIV) : 1;

    generate
        if (NUM_FRAMES < 1) begin : g_bad_frames
            $error("sprite_view: NUM_FRAMES must be >= 1");
        end
        if (ANIM_DIV < 1) begin : g_bad_div
            $error("sprite_view: ANIM_DIV must be >= 1");
        end
        if (ROM_LATENCY < 1) begin : g_bad_lat
            $error("sprite_view: ROM_LATENCY must be >= 1");
        end
    endgenerate

    // ---------------- shadow registers ----------------
    logic [COORD_W-1:0] x_sh_reg;
    logic [COORD_W-1:0] y_sh_reg;
    logic [3:0]         dir_sh_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_sh_reg   <= '0;
            y_sh_reg   <= '0;
            dir_sh_reg <= DIR_RIGHT;
        end else if (frame_tick) begin
            x_sh_reg <= spr_x;
            y_sh_reg <= spr_y;
            // a malformed direction keeps the sprite facing where it was
            if (is_onehot4(direction)) begin
                dir_sh_reg <= direction;
            end
        end
    end

    // ---------------- animation FSM ----------------
    anim_state_t     state_reg, state_next;
    logic [FW-1:0]   frame_reg, frame_next;
    logic [DW-1:0]   div_reg, div_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= ANIM_UP;
            frame_reg <= '0;
            div_reg   <= '0;
        end else begin
            state_reg <= state_next;
            frame_reg <= frame_next;
            div_reg   <= div_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        frame_next = frame_reg;
        div_next   = div_reg;
        if (anim_en && frame_tick) begin
            if (div_reg == DW'(ANIM_DIV - 1)) begin
                div_next = '0;
                if (NUM_FRAMES > 1) begin
                    case (state_reg)
                        ANIM_UP: begin
                            if (frame_reg == FW'(NUM_FRAMES - 1)) begin
                                state_next = ANIM_DOWN;
                                frame_next = frame_reg - FW'(1);
                            end else begin
                                frame_next = frame_reg + FW'(1);
                            end
                        end
                        default: begin
                            if (frame_reg == '0) begin
                                state_next = ANIM_UP;
                                frame_next = FW'(1);
                            end else begin
                                frame_next = frame_reg - FW'(1);
                            end
                        end
                    endcase
                end
            end else begin
                div_next = div_reg + DW'(1);
            end
        end
    end

    // ---------------- stage 0: hit test and orientation ----------------
    // One extra bit keeps x+SPR_SIZE from wrapping past the screen edge.
    logic [COORD_W:0] x_end;
    logic [COORD_W:0] y_end;
    logic             hit;
    logic [RW-1:0]    loc_r;
    logic [RW-1:0]    loc_c;
    logic [RW-1:0]    src_row;
    logic [RW-1:0]    src_col;
    logic [ROM_AW-1:0] addr_calc;

    assign x_end = {1'b0, x_sh_reg} + (COORD_W+1)'(SPR_SIZE);
    assign y_end = {1'b0, y_sh_reg} + (COORD_W+1)'(SPR_SIZE);
    assign hit   = (hc >= x_sh_reg) && ({1'b0, hc} < x_end) &&
                   (vc >= y_sh_reg) && ({1'b0, vc} < y_end);

    // low bits of the difference are exact whenever hit is true
    assign loc_r = RW'(vc) - RW'(y_sh_reg);
    assign loc_c = RW'(hc) - RW'(x_sh_reg);

    sprite_orient #(
        .SPR_SIZE (SPR_SIZE)
    ) u_orient (
        .r       (loc_r),
        .c       (loc_c),
        .dir     (dir_sh_reg),
        .src_row (src_row),
        .src_col (src_col)
    );

    assign addr_calc = ROM_AW'(frame_reg) * ROM_AW'(SPR_SIZE * SPR_SIZE)
                     + ROM_AW'(src_row) * ROM_AW'(SPR_SIZE)
                     + ROM_AW'(src_col);

    // ---------------- stage 1 and delay line ----------------
    // bit 0 is aligned with rom_addr, bit DLY with rom_data
    logic [DLY:0] hit_dly;
    logic [DLY:0] vld_dly;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rom_addr <= '0;
            hit_dly  <= '0;
            vld_dly  <= '0;
        end else begin
            if (hit) begin
                rom_addr <= addr_calc;
            end
            hit_dly <= {hit_dly[DLY-1:0], hit};
            vld_dly <= {vld_dly[DLY-1:0], px_vld};
        end
    end

    // ---------------- output stage ----------------
    logic fill_now;

    assign fill_now = vld_dly[DLY] && hit_dly[DLY] && (rom_data != TRANSPARENT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_vld     <= 1'b0;
            sprite_fill <= 1'b0;
            color_data  <= '0;
        end else begin
            out_vld     <= vld_dly[DLY];
            sprite_fill <= fill_now;
            color_data  <= fill_now ? rom_data : '0;
        end
    end

endmodule

// File: tb/tb_sprite_view.sv
module tb_sprite_view;

    localparam int SZ  = 30;
    localparam int NF  = 3;
    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        frame_tick = 1'b0;
    logic        px_vld = 1'b0;
    logic [9:0]  hc = '0;
    logic [9:0]  vc = '0;
    logic [9:0]  spr_x = '0;
    logic [9:0]  spr_y = '0;
    logic [3:0]  direction = 4'b0001;
    logic        anim_en = 1'b0;
    logic [11:0] rom_addr;
    logic [11:0] rom_data = '0;
    logic        out_vld;
    logic        sprite_fill;
    logic [11:0] color_data;

    int checks = 0;
    int errors = 0;

    sprite_view dut (
        .clk         (clk),
        .rst         (rst),
        .frame_tick  (frame_tick),
        .px_vld      (px_vld),
        .hc          (hc),
        .vc          (vc),
        .spr_x       (spr_x),
        .spr_y       (spr_y),
        .direction   (direction),
        .anim_en     (anim_en),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .out_vld     (out_vld),
        .sprite_fill (sprite_fill),
        .color_data  (color_data)
    );

    always #5 clk = ~clk;

    // Sprite ROM contents: distinct colour per address, a few transparent.
    function automatic logic [11:0] rom_f(input int a);
        if (a % 97 == 3) return 12'h000;
        return 12'(a + 256);
    endfunction

    always @(posedge clk) rom_data <= rom_f(int'(rom_addr));

    // ---------------- behavioural model ----------------
    typedef struct {
        bit vld;
        bit fill;
        int color;
        int addr;
    } exp_t;

    exp_t exp_q[$];

    int ms_x = 0, ms_y = 0, ms_dir = 1, ticks = 0, steps = 0, m_addr = 0;

    // frame after k animation steps of a 0..N-1..0 bounce
    function automatic int pp(input int k);
        int per, p;
        if (NF == 1) return 0;
        per = 2 * (NF - 1);
        p   = k % per;
        return (p < NF) ? p : per - p;
    endfunction

    function automatic bit onehot(input int d);
        return d == 1 || d == 2 || d == 4 || d == 8;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Applies one cycle of input, records what the outputs must become.
    task automatic drive(input bit px, input int h, input int v, input bit tk);
        exp_t e;
        bit   hit;
        int   r, c, sr, sc;
        px_vld     = px;
        hc         = 10'(h);
        vc         = 10'(v);
        frame_tick = tk;
        e.vld = 0; e.fill = 0; e.color = 0; e.addr = m_addr;
        if (!rst) begin
            hit = (h >= ms_x) && (h < ms_x + SZ) && (v >= ms_y) && (v < ms_y + SZ);
            if (hit) begin
                r = v - ms_y;
                c = h - ms_x;
                case (ms_dir)
                    2:       begin sr = r;          sc = SZ - 1 - c; end
                    4:       begin sr = c;          sc = SZ - 1 - r; end
                    8:       begin sr = SZ - 1 - c; sc = r;          end
                    default: begin sr = r;          sc = c;          end
                endcase
                m_addr = pp(steps) * SZ * SZ + sr * SZ + sc;
            end
            e.vld   = px;
            e.fill  = px && hit && (rom_f(m_addr) != 12'h000);
            e.color = e.fill ? int'(rom_f(m_addr)) : 0;
            e.addr  = m_addr;
            if (tk) begin
                ms_x = int'(spr_x);
                ms_y = int'(spr_y);
                if (onehot(int'(direction))) ms_dir = int'(direction);
                if (anim_en) begin
                    ticks++;
                    if (ticks % DIV == 0) steps++;
                end
            end
        end
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        frame_tick = 1'b0;
        px_vld     = 1'b0;
    endtask

    task automatic set_rst(input bit v);
        rst = v;
        if (v) begin
            foreach (exp_q[i]) begin
                exp_q[i].vld = 0; exp_q[i].fill = 0; exp_q[i].color = 0; exp_q[i].addr = 0;
            end
            ms_x = 0; ms_y = 0; ms_dir = 1; ticks = 0; steps = 0; m_addr = 0;
            #1;
            chk("rst_out_vld", int'(out_vld), 0);
            chk("rst_fill", int'(sprite_fill), 0);
            chk("rst_color", int'(color_data), 0);
            chk("rst_addr", int'(rom_addr), 0);
        end
    endtask

    task automatic tick();
        drive(0, 0, 0, 1);
    endtask

    // One pixel with literal expectations on the address and the fill.
    task automatic pixel_lit(input int h, input int v, input int ea, input int ef);
        drive(1, h, v, 0);
        chk($sformatf("addr(%0d,%0d)", h, v), int'(rom_addr), ea);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk($sformatf("fill(%0d,%0d)", h, v), int'(sprite_fill), ef);
    endtask

    // Per-cycle comparison against the model, entries are LATENCY=3 old.
    initial begin
        forever begin
            @(negedge clk);
            if (exp_q.size() >= 4) begin
                chk("m_out_vld", int'(out_vld), int'(exp_q[0].vld));
                chk("m_fill", int'(sprite_fill), int'(exp_q[0].fill));
                chk("m_color", int'(color_data), exp_q[0].color);
                chk("m_addr", int'(rom_addr), exp_q[2].addr);
                void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        int fr[4];
        fr = '{1, 2, 1, 0};
        repeat (3) drive(0, 0, 0, 0);
        set_rst(0);
        spr_x = 10'd100; spr_y = 10'd50; direction = 4'b0001;
        tick();

        // edges of the box, right-facing frame 0
        pixel_lit(100, 50, 0, 1);
        pixel_lit(129, 79, 899, 1);
        pixel_lit(130, 79, 899, 0);
        pixel_lit(99, 50, 899, 0);
        pixel_lit(100, 80, 899, 0);

        // orientation at r=0,c=5
        direction = 4'b0010; tick(); pixel_lit(105, 50, 24, 1);
        direction = 4'b0100; tick(); pixel_lit(105, 50, 179, 1);
        direction = 4'b1000; tick(); pixel_lit(105, 50, 720, 1);
        direction = 4'b0011; tick(); pixel_lit(105, 50, 720, 1);
        direction = 4'b0000; tick(); pixel_lit(105, 50, 720, 1);
        direction = 4'b0001; tick(); pixel_lit(105, 50, 5, 1);

        // transparency
        pixel_lit(103, 50, 3, 0);
        chk("transp_color", int'(color_data), 0);

        // shadowing: position only moves on frame_tick
        spr_x = 10'd200;
        pixel_lit(100, 50, 0, 1);
        drive(1, 101, 50, 1);   // tick and pixel together: old box
        chk("same_cycle_addr", int'(rom_addr), 1);
        drive(0, 0, 0, 0);
        drive(0, 0, 0, 0);
        chk("same_cycle_fill", int'(sprite_fill), 1);
        pixel_lit(101, 50, 1, 0);
        pixel_lit(200, 50, 0, 1);

        // right-edge wrap
        spr_x = 10'd1010; tick();
        pixel_lit(1023, 50, 13, 1);
        for (int h = 0; h < 5; h++) pixel_lit(h, 50, 13, 0);

        // animation 0,1,2,1,0
        spr_x = 10'd100; tick();
        anim_en = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            tick();
            if (i == 3) pixel_lit(100, 50, 0, 1);
            if (i % 4 == 0) pixel_lit(100, 50, fr[i/4 - 1] * 900, 1);
        end
        // freeze mid-count and resume
        repeat (2) tick();
        anim_en = 1'b0;
        repeat (5) tick();
        pixel_lit(100, 50, 0, 1);
        anim_en = 1'b1;
        repeat (2) tick();
        pixel_lit(100, 50, 900, 1);

        // reset mid-scan with hits in flight
        for (int i = 0; i < 4; i++) drive(1, 100 + i, 50, 0);
        set_rst(1);
        for (int i = 0; i < 3; i++) drive(1, 100 + i, 50, 0);
        chk("in_rst_fill", int'(sprite_fill), 0);
        set_rst(0);
        tick();
        drive(1, 100, 50, 0);
        drive(0, 0, 0, 0);
        chk("post_rst_early", int'(sprite_fill), 0);
        drive(0, 0, 0, 0);
        chk("post_rst_fill", int'(sprite_fill), 1);
        chk("post_rst_color", int'(color_data), 12'h100);

        repeat (4) drive(0, 0, 0, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
